// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches words from a synchronous instruction memory and
// issues them to the cpu at a fixed cadence, stalling on tensor operates and stopping at the halt sentinel.
module program_sequencer #(
    parameter int                     ADDR_WIDTH     = 10,
    parameter int                     INSTR_WIDTH    = 16,
    parameter int                     ISSUE_INTERVAL = 2,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD      = 16'hFFFF,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD       = 16'h9000,
    parameter int                     TENSOR_TIMEOUT = 255
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    output logic [ADDR_WIDTH-1:0]  imem_addr_out,
    output logic                   imem_rd_en_out,
    input  logic [INSTR_WIDTH-1:0] imem_data_in,
    input  logic                   tensor_core_done_in,
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic                   instruction_valid_out,
    output logic                   busy_out,
    output logic                   halted_out,
    output logic                   error_out,
    output logic [ADDR_WIDTH:0]    instruction_count_out
);

    localparam int HOLD_W = $clog2(ISSUE_INTERVAL + 1);
    localparam int TO_W   = $clog2(TENSOR_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] PC_LAST   = '1;
    localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX   = '1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(ISSUE_INTERVAL);
    localparam logic [TO_W-1:0]       TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TENSOR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_WAIT_TENSOR,
        S_HALTED
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_rd_en;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_halted;
    logic                   r_error;
    logic [ADDR_WIDTH:0]    r_count;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [TO_W-1:0]        r_to_cnt;

    logic w_is_tensor;
    logic w_pc_last;

    assign w_is_tensor = (r_instr[INSTR_WIDTH-1 -: 4] == 4'b0101);
    assign w_pc_last   = (r_pc == PC_LAST);

    assign imem_addr_out         = r_pc;
    assign imem_rd_en_out        = r_rd_en;
    assign current_instruction   = r_instr;
    assign instruction_valid_out = r_valid;
    assign busy_out              = r_busy;
    assign halted_out            = r_halted;
    assign error_out             = r_error;
    assign instruction_count_out = r_count;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_rd_en    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start_in) begin
                        r_pc     <= '0;
                        r_count  <= '0;
                        r_error  <= 1'b0;
                        r_halted <= 1'b0;
                        r_busy   <= 1'b1;
                        r_rd_en  <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // The sentinel ends the program without ever reaching the cpu.
                    if (imem_data_in == HALT_WORD) begin
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_HALTED;
                    end else begin
                        r_instr    <= imem_data_in;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= HOLD_ONE;
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + CNT_ONE;
                        end
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt >= HOLD_LAST) begin
                        r_instr <= NOP_WORD;
                        if (w_is_tensor) begin
                            r_to_cnt <= '0;
                            r_state  <= S_WAIT_TENSOR;
                        end else if (w_pc_last) begin
                            r_halted <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_HALTED;
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_rd_en <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end
                S_WAIT_TENSOR: begin
                    r_to_cnt <= r_to_cnt + TO_ONE;
                    // A done flag in the first wait cycle may be left over from the previous operation.
                    if (tensor_core_done_in && (r_to_cnt != '0)) begin
                        if (w_pc_last) begin
                            r_halted <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_HALTED;
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_rd_en <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else if (r_to_cnt >= TO_LAST) begin
                        r_error  <= 1'b1;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_HALTED;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: table-driven programs, a scoreboard of
// expected issues, and hand-written tensor-stall, timeout, full-memory and reset sequences.
module tb_program_sequencer;

    localparam logic [15:0] NOP  = 16'h9000;
    localparam logic [15:0] HALT = 16'hFFFF;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] w [4];
        int          exp_count;
        int          exp_halt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        done = 1'b0;
    logic        done_b = 1'b0;
    logic [9:0]  addr, addr_b;
    logic        rd, rd_b;
    logic [15:0] rdata = 16'h0000;
    logic [15:0] rdata_b = 16'h0000;
    logic [15:0] instr, instr_b;
    logic        valid, valid_b, busy, busy_b, halted, halted_b, error, error_b;
    logic [10:0] count, count_b;
    logic [15:0] mem [1024];

    program_sequencer dut (
        .clock_in(clk), .reset_in(rst), .start_in(start),
        .imem_addr_out(addr), .imem_rd_en_out(rd), .imem_data_in(rdata),
        .tensor_core_done_in(done), .current_instruction(instr),
        .instruction_valid_out(valid), .busy_out(busy), .halted_out(halted),
        .error_out(error), .instruction_count_out(count)
    );

    program_sequencer #(.TENSOR_TIMEOUT(8)) dut_to (
        .clock_in(clk), .reset_in(rst), .start_in(start_b),
        .imem_addr_out(addr_b), .imem_rd_en_out(rd_b), .imem_data_in(rdata_b),
        .tensor_core_done_in(done_b), .current_instruction(instr_b),
        .instruction_valid_out(valid_b), .busy_out(busy_b), .halted_out(halted_b),
        .error_out(error_b), .instruction_count_out(count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd)   rdata   <= mem[addr];
        if (rd_b) rdata_b <= mem[addr_b];
    end

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          t0 = 0;
    bit          mon_en = 1'b0;
    bit          prev_valid = 1'b0;
    logic [15:0] prev_word = 16'h0;
    int          halt_seen = 0;
    int          fetch0 = 0;
    exp_t        sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (instr == HALT) halt_seen++;
            if (rd && addr == 10'd0) fetch0++;
            if (prev_valid) begin
                chk("hold_word", int'(instr), int'(prev_word));
                chk("hold_valid_low", int'(valid), 0);
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=%0h required=none (cycle %0d)", instr, cyc - t0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("issue_word", int'(instr), int'(e.word));
                    chk("issue_cycle", cyc - t0, e.cyc);
                end
            end
            prev_valid = valid;
            prev_word  = instr;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        t0         = cyc;
        prev_valid = 1'b0;
        halt_seen  = 0;
        fetch0     = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int rel);
        while (!halted && (cyc - t0) < budget) @(negedge clk);
        rel = cyc - t0;
        chk("halt_reached", int'(halted), 1);
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 1024; i++) mem[i] = w;
    endtask

    task automatic push_model();
        for (int i = 0; i < 1024 && mem[i] != HALT; i++) sb.push_back('{mem[i], 3 + 4 * i});
    endtask

    vec_t tbl [4];
    int   rel;
    int   first_fetch;
    int   early_rd;

    initial begin
        tbl[0] = '{'{16'hA105, 16'h0012, HALT, HALT}, 2, 11};
        tbl[1] = '{'{HALT, 16'h1111, 16'h2222, HALT}, 0, 3};
        tbl[2] = '{'{16'h0001, 16'h0002, 16'h0003, HALT}, 3, 15};
        tbl[3] = '{'{16'h4FFF, 16'hFFFE, 16'h9000, HALT}, 3, 15};
        fill(HALT);

        repeat (3) @(negedge clk);
        chk("rst_instr", int'(instr), int'(NOP));
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_instr", int'(instr), int'(NOP));
        chk("idle_halted", int'(halted), 0);
        chk("idle_count", int'(count), 0);
        chk("idle_rd", int'(rd), 0);
        chk("idle_addr", int'(addr), 0);
        chk("idle_error", int'(error), 0);
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            fill(HALT);
            for (int i = 0; i < 4; i++) mem[i] = tbl[v].w[i];
            push_model();
            do_start();
            chk("start_busy", int'(busy), 1);
            wait_halt(200, rel);
            chk("halt_cycle", rel, tbl[v].exp_halt);
            chk("halt_count", int'(count), tbl[v].exp_count);
            chk("halt_busy", int'(busy), 0);
            chk("sb_drained", sb.size(), 0);
            chk("no_halt_word", halt_seen, 0);
        end

        // Tensor stall: done low until cycle 13, then high.
        fill(HALT);
        mem[0] = 16'h5000; mem[1] = 16'h9000;
        sb.push_back('{16'h5000, 3});
        sb.push_back('{16'h9000, 16});
        done = 1'b0; first_fetch = -1; early_rd = 0;
        do_start();
        for (int k = 0; k < 60 && !halted; k++) begin
            @(negedge clk);
            rel  = cyc - t0;
            done = (rel >= 13);
            if (rd && rel >= 5 && rel <= 13) early_rd++;
            if (rd && rel >= 5 && first_fetch < 0) first_fetch = rel;
        end
        chk("stall_no_fetch", early_rd, 0);
        chk("stall_fetch_cycle", first_fetch, 14);
        wait_halt(100, rel);
        chk("stall_halt_cycle", rel, 20);
        chk("stall_count", int'(count), 2);
        chk("stall_sb", sb.size(), 0);

        // Stale done in the first wait cycle is ignored; release one cycle later.
        sb.push_back('{16'h5000, 3});
        sb.push_back('{16'h9000, 9});
        done = 1'b1; first_fetch = -1;
        do_start();
        for (int k = 0; k < 40 && !halted; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rd && rel >= 5 && first_fetch < 0) first_fetch = rel;
        end
        done = 1'b0;
        chk("blank_fetch_cycle", first_fetch, 7);
        wait_halt(100, rel);
        chk("blank_halt_cycle", rel, 13);
        chk("blank_sb", sb.size(), 0);

        // Timeout instance (TENSOR_TIMEOUT=8), done stuck low.
        fill(HALT);
        mem[0] = 16'h5000;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (11) @(negedge clk);
        chk("to_err_before", int'(error_b), 0);
        chk("to_busy_before", int'(busy_b), 1);
        @(negedge clk);
        chk("to_err_after", int'(error_b), 1);
        chk("to_halted", int'(halted_b), 1);
        chk("to_count", int'(count_b), 1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("to_err_cleared", int'(error_b), 0);
        chk("to_restart_busy", int'(busy_b), 1);

        // Whole memory without sentinel.
        fill(16'h0000);
        push_model();
        do_start();
        wait_halt(5000, rel);
        chk("full_halt_cycle", rel, 4097);
        chk("full_count", int'(count), 1024);
        chk("full_pc", int'(addr), 1023);
        chk("full_fetch0", fetch0, 1);
        chk("full_sb", sb.size(), 0);

        // Asynchronous reset while holding the first instruction.
        fill(HALT);
        mem[0] = 16'h1234; mem[1] = 16'h2345;
        sb.push_back('{16'h1234, 3});
        do_start();
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_rst_instr", int'(instr), 16'h1234);
        mon_en = 1'b0;
        prev_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_instr", int'(instr), int'(NOP));
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_sb", sb.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Start during busy must not restart the program.
        sb.push_back('{16'h1234, 3});
        sb.push_back('{16'h2345, 7});
        do_start();
        while ((cyc - t0) < 8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_addr", int'(addr), 2);
        chk("busy_start_rd", int'(rd), 1);
        wait_halt(100, rel);
        chk("busy_start_halt", rel, 11);
        chk("busy_start_count", int'(count), 2);
        chk("busy_start_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
